// File: rtl/uart_bus_bridge.sv
// Memory-mapped bridge between the CPU peripheral bus and the UART core, with RX/TX byte FIFOs.
// Build with UART_BRIDGE_IRQ_EN defined to get the CTRL register and the interrupt output.
module uart_bus_bridge #(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic        sysclk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        wr,
   input  logic        rd,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq,
   input  logic [7:0]  UART_RXD,
   input  logic        RX_EFF,
   output logic        RX_READ,
   output logic [7:0]  UART_TXD,
   output logic        TX_EN,
   input  logic        TX_STATUS
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   typedef logic [DEPTH_LOG2-1:0] ptr_t;
   typedef logic [DEPTH_LOG2:0]   cnt_t;
   localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

   localparam logic [1:0] A_TXD    = 2'd0;
   localparam logic [1:0] A_RXD    = 2'd1;
   localparam logic [1:0] A_STATUS = 2'd2;
   localparam logic [1:0] A_CTRL   = 2'd3;

   typedef enum logic {RX_IDLE, RX_ACK}  rx_state_t;
   typedef enum logic {TX_IDLE, TX_WAIT} tx_state_t;

   rx_state_t  rx_state_q;
   tx_state_t  tx_state_q;
   logic       rx_read_q, tx_en_q;
   logic [7:0] txd_q;

   logic [7:0] rx_mem_q [DEPTH];
   logic [7:0] tx_mem_q [DEPTH];
   ptr_t       rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   ptr_t       tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   cnt_t       rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
   logic       tx_drop_q, tx_drop_d;
   logic [1:0] ctrl_q, ctrl_d;
   logic       irq_q, irq_d;

   logic rx_full, rx_empty, tx_full, tx_empty;
   logic rx_push, rx_pop, tx_push, tx_pop, tx_drop_evt, status_rd;
   logic unused_wdata;

   assign unused_wdata = ^wdata[31:8];

   // Full/empty come from the pre-edge counts, so a pop never frees a slot for a same-cycle push.
   assign rx_full     = (rx_cnt_q == CNT_FULL);
   assign rx_empty    = (rx_cnt_q == '0);
   assign tx_full     = (tx_cnt_q == CNT_FULL);
   assign tx_empty    = (tx_cnt_q == '0);
   assign rx_push     = (rx_state_q == RX_IDLE) && RX_EFF && !rx_full;
   assign rx_pop      = rd && (addr == A_RXD) && !rx_empty;
   assign tx_push     = wr && (addr == A_TXD) && !tx_full;
   assign tx_drop_evt = wr && (addr == A_TXD) && tx_full;
   assign tx_pop      = (tx_state_q == TX_IDLE) && !tx_empty && TX_STATUS;
   assign status_rd   = rd && (addr == A_STATUS);

   always_comb begin
      rx_wp_d  = rx_wp_q + ptr_t'(rx_push);
      rx_rp_d  = rx_rp_q + ptr_t'(rx_pop);
      rx_cnt_d = rx_cnt_q + cnt_t'(rx_push) - cnt_t'(rx_pop);
      tx_wp_d  = tx_wp_q + ptr_t'(tx_push);
      tx_rp_d  = tx_rp_q + ptr_t'(tx_pop);
      tx_cnt_d = tx_cnt_q + cnt_t'(tx_push) - cnt_t'(tx_pop);
      // A drop in the same cycle as a STATUS read must survive the clear.
      tx_drop_d = tx_drop_evt | (tx_drop_q & !status_rd);
`ifdef UART_BRIDGE_IRQ_EN
      ctrl_d = (wr && (addr == A_CTRL)) ? wdata[1:0] : ctrl_q;
      irq_d  = (ctrl_q[0] & !rx_empty) | (ctrl_q[1] & tx_empty);
`else
      ctrl_d = 2'b00;
      irq_d  = 1'b0;
`endif
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         rx_wp_q   <= '0;
         rx_rp_q   <= '0;
         rx_cnt_q  <= '0;
         tx_wp_q   <= '0;
         tx_rp_q   <= '0;
         tx_cnt_q  <= '0;
         tx_drop_q <= 1'b0;
         ctrl_q    <= 2'b00;
         irq_q     <= 1'b0;
      end else begin
         rx_wp_q   <= rx_wp_d;
         rx_rp_q   <= rx_rp_d;
         rx_cnt_q  <= rx_cnt_d;
         tx_wp_q   <= tx_wp_d;
         tx_rp_q   <= tx_rp_d;
         tx_cnt_q  <= tx_cnt_d;
         tx_drop_q <= tx_drop_d;
         ctrl_q    <= ctrl_d;
         irq_q     <= irq_d;
      end
   end

   always_ff @(posedge sysclk) begin
      if (rx_push) rx_mem_q[rx_wp_q] <= UART_RXD;
      if (tx_push) tx_mem_q[tx_wp_q] <= wdata[7:0];
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         rx_state_q <= RX_IDLE;
         rx_read_q  <= 1'b0;
      end else begin
         case (rx_state_q)
            RX_IDLE: begin
               rx_read_q <= 1'b0;
               if (rx_push) begin
                  rx_read_q  <= 1'b1;
                  rx_state_q <= RX_ACK;
               end
            end
            RX_ACK: begin
               rx_read_q <= 1'b0;
               if (!RX_EFF) rx_state_q <= RX_IDLE;
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         tx_state_q <= TX_IDLE;
         tx_en_q    <= 1'b0;
         txd_q      <= 8'h00;
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               tx_en_q <= 1'b0;
               if (tx_pop) begin
                  txd_q      <= tx_mem_q[tx_rp_q];
                  tx_en_q    <= 1'b1;
                  tx_state_q <= TX_WAIT;
               end
            end
            TX_WAIT: begin
               tx_en_q <= 1'b0;
               if (!TX_STATUS) tx_state_q <= TX_IDLE;
            end
            default: tx_state_q <= TX_IDLE;
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      if (rd) begin
         case (addr)
            A_RXD: if (!rx_empty) rdata[7:0] = rx_mem_q[rx_rp_q];
            A_STATUS: begin
               rdata[0]                = !rx_empty;
               rdata[1]                = tx_full;
               rdata[2]                = tx_empty;
               rdata[3]                = tx_drop_q;
               rdata[4+:DEPTH_LOG2+1]  = rx_cnt_q;
            end
            A_CTRL:  rdata[1:0] = ctrl_q;
            default: rdata = '0;
         endcase
      end
   end

   assign RX_READ  = rx_read_q;
   assign TX_EN    = tx_en_q;
   assign UART_TXD = txd_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench for uart_bus_bridge: UART core models plus RX/TX byte scoreboards.
module tb_uart_bus_bridge;

   logic        sysclk = 1'b0;
   logic        reset;
   logic [1:0]  addr;
   logic        wr, rd;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;
   logic [7:0]  UART_RXD;
   logic        RX_EFF;
   logic        RX_READ;
   logic [7:0]  UART_TXD;
   logic        TX_EN;
   logic        TX_STATUS;

   uart_bus_bridge #(.DEPTH_LOG2(2)) dut (
      .sysclk(sysclk), .reset(reset), .addr(addr), .wr(wr), .rd(rd),
      .wdata(wdata), .rdata(rdata), .irq(irq),
      .UART_RXD(UART_RXD), .RX_EFF(RX_EFF), .RX_READ(RX_READ),
      .UART_TXD(UART_TXD), .TX_EN(TX_EN), .TX_STATUS(TX_STATUS)
   );

   always #5 sysclk = ~sysclk;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   logic [7:0] rx_src[$];
   logic [7:0] rx_exp[$];
   logic [7:0] tx_exp[$];

   int rx_pres_cyc, rx_ack_cyc, rx_lat, rx_ack_cnt = 0;
   int tx_en_cyc, tx_en_cnt = 0;
   int irq_rise_cyc, irq_fall_cyc, irq_rise_cnt = 0;
   int wr_cyc, rd_cyc;
   int tx_busy_len = 5;
   logic tx_hold = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s act=0x%0h exp=0x%0h @cyc %0d", tag, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge sysclk);
      cyc++;
   end

   // UART receiver: presents one byte, drops it once acknowledged.
   initial begin
      RX_EFF = 1'b0;
      UART_RXD = 8'h00;
      forever begin
         @(posedge sysclk); #1;
         if (RX_EFF) begin
            if (RX_READ) RX_EFF = 1'b0;
         end else if (reset && rx_src.size() > 0) begin
            UART_RXD = rx_src.pop_front();
            RX_EFF = 1'b1;
            rx_pres_cyc = cyc;
         end
      end
   end

   // UART transmitter: busy for tx_busy_len cycles after each launch.
   initial begin
      int busy = 0;
      TX_STATUS = 1'b1;
      forever begin
         @(posedge sysclk); #1;
         if (TX_EN) busy = tx_busy_len;
         else if (busy > 0) busy--;
         TX_STATUS = !tx_hold && (busy == 0);
      end
   end

   initial begin
      logic irq_prev = 1'b0;
      forever begin
         @(negedge sysclk);
         if (reset) begin
            if (RX_READ) begin
               rx_ack_cnt++;
               rx_ack_cyc = cyc;
               rx_lat = cyc - rx_pres_cyc;
            end
            if (TX_EN) begin
               tx_en_cnt++;
               tx_en_cyc = cyc;
               if (tx_exp.size() > 0) chk("txd", {24'b0, UART_TXD}, {24'b0, tx_exp.pop_front()});
               else chk("tx_spurious", {31'b0, TX_EN}, 32'd0);
            end
            if (irq && !irq_prev) begin irq_rise_cnt++; irq_rise_cyc = cyc; end
            if (!irq && irq_prev) irq_fall_cyc = cyc;
         end
         irq_prev = irq;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cyc %0d", cyc);
      $fatal(1, "timeout");
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge sysclk); #1; end
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      addr = a; wdata = d; wr = 1'b1; wr_cyc = cyc;
      @(posedge sysclk); #1;
      wr = 1'b0;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
      addr = a; rd = 1'b1; rd_cyc = cyc;
      @(negedge sysclk);
      d = rdata;
      @(posedge sysclk); #1;
      rd = 1'b0;
   endtask

   task automatic chk_status(input string tag, input logic [31:0] exp);
      logic [31:0] d;
      bus_rd(2'd2, d);
      chk(tag, d, exp);
   endtask

   task automatic rd_rxd();
      logic [31:0] d;
      bus_rd(2'd1, d);
      if (rx_exp.size() > 0) chk("rxd", d, {24'b0, rx_exp.pop_front()});
      else chk("rxd_empty", d, 32'd0);
   endtask

   initial begin
      logic [31:0] d;
      int base, w0;
      logic seen;
      reset = 1'b0; addr = 2'd0; wr = 1'b0; rd = 1'b0; wdata = '0;
      #23;
      chk("rst_outputs", {22'b0, RX_READ, TX_EN, UART_TXD, irq}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      @(posedge sysclk); #1;
      reset = 1'b1;
      idle(2);
      chk_status("status_reset", 32'h04);

      // single received byte
      rx_src.push_back(8'h5A); rx_exp.push_back(8'h5A);
      idle(4);
      chk("rx_ack_cnt1", rx_ack_cnt, 1);
      chk("rx_latency", rx_lat, 1);
      chk_status("status_rx1", 32'h15);
      rd_rxd();
      chk_status("status_rx_drained", 32'h04);

      // overflow the RX FIFO by one byte
      base = rx_ack_cnt;
      for (int i = 1; i <= 5; i++) begin
         rx_src.push_back(8'(i)); rx_exp.push_back(8'(i));
      end
      idle(20);
      chk("rx_ack_full", rx_ack_cnt - base, 4);
      chk_status("status_rx_full", 32'h45);
      chk("rx_held", {23'b0, RX_EFF, UART_RXD}, 32'h105);
      rd_rxd();
      idle(3);
      chk("rx_ack_after_pop", rx_ack_cnt - base, 5);
      repeat (4) rd_rxd();
      rd_rxd();
      chk("rx_sb_empty", rx_exp.size(), 0);

      // two TX bytes, second waits for the transmitter
      base = tx_en_cnt;
      tx_exp.push_back(8'hA1);
      bus_wr(2'd0, 32'h0000_00A1);
      w0 = wr_cyc;
      tx_exp.push_back(8'hA2);
      bus_wr(2'd0, 32'hFFFF_FFA2);
      idle(2);
      chk("tx_first_only", tx_en_cnt - base, 1);
      chk("tx_latency", tx_en_cyc - w0, 2);
      idle(15);
      chk("tx_second", tx_en_cnt - base, 2);

      // TX FIFO overflow with transmitter busy
      tx_hold = 1'b1;
      idle(1);
      base = tx_en_cnt;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) tx_exp.push_back(8'hB0 + 8'(i));
         bus_wr(2'd0, 32'hB0 + i);
      end
      chk_status("status_tx_full_drop", 32'h0A);
      chk_status("status_drop_cleared", 32'h02);
      chk("tx_held", tx_en_cnt - base, 0);
      tx_hold = 1'b0;
      idle(40);
      chk("tx_drained", tx_en_cnt - base, 4);
      chk("tx_sb_empty", tx_exp.size(), 0);
      chk_status("status_tx_idle", 32'h04);

      // interrupt path
      base = irq_rise_cnt;
      bus_wr(2'd3, 32'h1);
      bus_rd(2'd3, d);
`ifdef UART_BRIDGE_IRQ_EN
      chk("ctrl_read", d, 32'h1);
`else
      chk("ctrl_read", d, 32'h0);
`endif
      idle(2);
      chk("irq_idle", {31'b0, irq}, 32'd0);
      rx_src.push_back(8'h77); rx_exp.push_back(8'h77);
      idle(5);
`ifdef UART_BRIDGE_IRQ_EN
      chk("irq_set", {31'b0, irq}, 32'd1);
      chk("irq_rise_lag", irq_rise_cyc - rx_ack_cyc, 1);
      rd_rxd();
      idle(3);
      chk("irq_clr", {31'b0, irq}, 32'd0);
      chk("irq_fall_lag", irq_fall_cyc - rd_cyc, 2);
      bus_wr(2'd3, 32'h2);
      idle(3);
      chk("irq_tx_empty", {31'b0, irq}, 32'd1);
`else
      chk("irq_off", {31'b0, irq}, 32'd0);
      rd_rxd();
      bus_wr(2'd3, 32'h2);
      idle(3);
      chk("irq_never", irq_rise_cnt - base, 0);
`endif
      bus_wr(2'd3, 32'h0);
      idle(3);
      chk("irq_ctrl_off", {31'b0, irq}, 32'd0);

      // reset in the middle of TX_WAIT and RX_ACK
      tx_busy_len = 20;
      base = tx_en_cnt;
      tx_exp.push_back(8'hC3);
      bus_wr(2'd0, 32'hC3);
      for (int i = 0; i < 10 && tx_en_cnt == base; i++) idle(1);
      chk("tx_launch_pre_rst", tx_en_cnt - base, 1);
      rx_src.push_back(8'h99);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge sysclk);
         seen = RX_READ;
      end
      chk("rx_read_seen", {31'b0, seen}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("rst_mid_outputs", {22'b0, RX_READ, TX_EN, UART_TXD, irq}, 32'd0);
      @(posedge sysclk); #1;
      reset = 1'b1;
      base = tx_en_cnt;
      idle(25);
      chk("no_tx_after_rst", tx_en_cnt - base, 0);
      chk_status("status_after_rst", 32'h04);
      rd_rxd();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/uart_bus_bridge.md
# uart_bus_bridge

Memory-mapped bridge between the CPU peripheral bus and the UART core. Buffers received bytes from the UART receiver in an RX FIFO and queues bytes written by software in a TX FIFO, and drives the UART core's one-byte handshake (UART_RXD/RX_EFF/RX_READ, UART_TXD/TX_EN/TX_STATUS) autonomously. Sits directly downstream of the UART receiver and upstream of the UART transmitter, alongside the other peripherals on the data bus.

## Interface
- DEPTH_LOG2, 2, log2 of each FIFO depth (default depth 4)
- sysclk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- addr  in  2  register select, word offset: 0 TXD, 1 RXD, 2 STATUS, 3 CTRL
- wr  in  1  bus write strobe, one access per cycle high
- rd  in  1  bus read strobe, one access per cycle high
- wdata  in  32  bus write data
- rdata  out  32  bus read data, combinational, valid while rd=1, else 0
- irq  out  1  registered interrupt request
- UART_RXD  in  8  received byte from UART core
- RX_EFF  in  1  UART core holds a valid received byte
- RX_READ  out  1  one-cycle acknowledge of the received byte
- UART_TXD  out  8  byte to transmit
- TX_EN  out  1  one-cycle transmit launch strobe
- TX_STATUS  in  1  UART transmitter idle (1 = ready)

## Operation
- UART core contract: RX_EFF falls within 1 cycle after RX_READ; TX_STATUS falls within 1 cycle after TX_EN and returns high when the frame ends.
- RX FSM, states RX_IDLE/RX_ACK. RX_IDLE: if RX_EFF=1 and RX FIFO not full, push UART_RXD, RX_READ=1 next cycle, go RX_ACK. RX_ACK: RX_READ=0; stay until RX_EFF=0, then RX_IDLE. RX FIFO full: byte left in UART core, no acknowledge.
- TX FSM, states TX_IDLE/TX_WAIT. TX_IDLE: if TX FIFO not empty and TX_STATUS=1, pop head into UART_TXD, TX_EN=1 for one cycle, go TX_WAIT. TX_WAIT: stay until TX_STATUS=0, then TX_IDLE. UART_TXD holds last byte launched.
- Write TXD: push wdata[7:0]; if TX full, byte dropped and STATUS.tx_drop set.
- Read RXD: rdata = {24'b0, head}, pop at end of cycle; RX empty returns 0, no pop.
- Read STATUS: bit0 rx_nonempty, bit1 tx_full, bit2 tx_empty, bit3 tx_drop (sticky; cleared at end of the STATUS read), bits [4+DEPTH_LOG2:4] RX occupancy, rest 0.
- CTRL (R/W): bit0 rx_irq_en, bit1 tx_irq_en, rest read 0.
- irq register = (rx_irq_en & rx_nonempty) | (tx_irq_en & tx_empty).
- Writes to RXD/STATUS ignored; reads of TXD return 0.
- FIFO pointers DEPTH_LOG2 bits wrap modulo depth; counts DEPTH_LOG2+1 bits, range 0..2^DEPTH_LOG2.

## Timing
- Reset (async assert, sync-effective deassert): FIFOs empty, FSMs idle, RX_READ=0, TX_EN=0, UART_TXD=0, irq=0, CTRL=0, tx_drop=0. Reset mid-operation discards all buffered bytes; no partial strobes.
- RX latency: RX_EFF rising to RX_READ pulse = 1 cycle; byte readable on bus the cycle after push edge.
- TX latency: TXD write edge to TX_EN = 1 cycle if TX_STATUS=1 and FIFO was empty.
- Full/empty use pre-edge values: simultaneous bus pop of full RX FIFO and RX capture → capture deferred one cycle; simultaneous TXD write into empty TX FIFO → launch next cycle.
- Simultaneous TX push and launch pop on non-empty, non-full FIFO: both occur, count unchanged.
- irq lags the causing state by 1 cycle.

## Configuration
- UART_BRIDGE_IRQ_EN defined: CTRL register and irq logic as above.
- Not defined: irq tied 0, CTRL writes ignored and reads 0; all else unchanged.

## Test plan
- Reset asserted mid-RX_ACK and mid-TX_WAIT → all outputs 0 immediately, STATUS reads 0x04 after release.
- UART presents 0x5A with RX_EFF=1 → RX_READ pulse 1 cycle later, STATUS bit0=1, RXD read returns 0x5A, then STATUS=0x04.
- Five bytes 0x01..0x05 offered, no bus reads (depth 4) → four RX_READ pulses, occupancy 4, 0x05 held in core until first RXD read, then captured; reads return 0x01..0x05 in order.
- Write 0xA1,0xA2 with TX_STATUS=1 → TX_EN with UART_TXD=0xA1; 0xA2 launched only after TX_STATUS goes low then high.
- Six TXD writes with TX_STATUS=0 → four queued, STATUS bits1 and 3 set; STATUS read clears bit3.
- CTRL=0x1, RX byte arrives → irq=1 one cycle after push, falls one cycle after FIFO drains; with macro undefined irq stays 0.
